// File: rtl/tx_os_sequencer_if.sv
// Handshake and control bundle between the LTSSM and the transmit ordered-set sequencer.
// The master side is the LTSSM/TX datapath; the slave side is the sequencer itself.
interface tx_os_sequencer_if;
    logic          start;
    logic          stop;
    logic [3:0]    substate;
    logic [7:0]    linkNumber;
    logic [7:0]    rateId;
    logic          upConfigureCapability;
    logic [4:0]    numberOfDetectedLanes;
    logic          osReady;
    logic [2047:0] orderedSets;
    logic          osValid;
    logic          txElectricalIdle;
    logic          finish;
    logic          busy;
    logic [10:0]   sentCount;

    modport master (
        output start, stop, substate, linkNumber, rateId, upConfigureCapability,
               numberOfDetectedLanes, osReady,
        input  orderedSets, osValid, txElectricalIdle, finish, busy, sentCount
    );

    modport slave (
        input  start, stop, substate, linkNumber, rateId, upConfigureCapability,
               numberOfDetectedLanes, osReady,
        output orderedSets, osValid, txElectricalIdle, finish, busy, sentCount
    );
endinterface

// File: rtl/tx_os_sequencer.sv
// Transmit-side ordered-set sequencer: builds per-lane TS1/TS2/idle payloads for the
// latched LTSSM substate, streams them over valid/ready and signals the minimum count.
module tx_os_sequencer #(
    parameter logic       DEVICETYPE = 1'b0,
    parameter logic [7:0] NFTS       = 8'd16
) (
    input  logic               clk,
    input  logic               reset,
    tx_os_sequencer_if.slave   seqIf
);

    typedef enum logic [1:0] {IDLE, SEND, HOLD, QUIET} seqStateT;
    typedef enum logic [1:0] {OS_NONE, OS_TS1, OS_TS2, OS_ZERO} osKindT;

    localparam logic [7:0] PAD = 8'hF7;

    seqStateT    state, nextState;
    logic [3:0]  subReg;
    logic [7:0]  linkReg;
    logic [7:0]  rateReg;
    logic        upcReg;
    logic [4:0]  lanesReg;
    logic [10:0] sentCount;
    logic        startDly;

    osKindT      osKind;
    logic        useLink;
    logic        useLane;
    logic [10:0] minCount;

    logic        osValid;
    logic        accept;
    logic        finish;
    logic        txElecIdle;
    logic [2047:0] payload;

    function automatic logic isQuiet(input logic [3:0] sub);
        return (sub <= 4'd1) || (sub >= 4'd10);
    endfunction

    // Per-substate ordered-set type, field sources and minimum transmit count.
    always_comb begin
        osKind   = OS_NONE;
        useLink  = 1'b0;
        useLane  = 1'b0;
        minCount = '0;
        case (subReg)
            4'd2: begin osKind = OS_TS1; minCount = 11'd1024; end
            4'd3: begin osKind = OS_TS2; minCount = 11'd16; end
            4'd4: begin osKind = OS_TS1; useLink = DEVICETYPE; minCount = 11'd16; end
            4'd5: begin osKind = OS_TS1; useLink = 1'b1; minCount = 11'd2; end
            4'd6, 4'd7: begin
                osKind = OS_TS1; useLink = 1'b1; useLane = 1'b1; minCount = 11'd2;
            end
            4'd8: begin
                osKind = OS_TS2; useLink = 1'b1; useLane = 1'b1; minCount = 11'd16;
            end
            4'd9: begin osKind = OS_ZERO; minCount = 11'd16; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState  = state;
        finish     = 1'b0;
        osValid    = (state == SEND) || (state == HOLD);
        accept     = osValid && seqIf.osReady;
        txElecIdle = (state == QUIET) && (subReg <= 4'd1);
        case (state)
            SEND: begin
                if (accept && (sentCount + 11'd1 == minCount)) begin
                    nextState = HOLD;
                    finish    = 1'b1;
                end
            end
            QUIET: finish = startDly;
            default: ;
        endcase
        if (seqIf.start) begin
            nextState = isQuiet(seqIf.substate) ? QUIET : SEND;
        end else if (seqIf.stop) begin
            nextState = IDLE;
        end
    end

    // Per-sequence context is captured only on start so mid-sequence input changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            subReg    <= '0;
            linkReg   <= '0;
            rateReg   <= '0;
            upcReg    <= 1'b0;
            lanesReg  <= '0;
            sentCount <= '0;
            startDly  <= 1'b0;
        end else begin
            startDly <= seqIf.start;
            if (seqIf.start) begin
                subReg    <= seqIf.substate;
                linkReg   <= seqIf.linkNumber;
                rateReg   <= seqIf.rateId;
                upcReg    <= seqIf.upConfigureCapability;
                lanesReg  <= (seqIf.numberOfDetectedLanes > 5'd16) ? 5'd16
                                                                   : seqIf.numberOfDetectedLanes;
                sentCount <= '0;
            end else if (seqIf.stop) begin
                sentCount <= '0;
            end else if (accept && (sentCount != 11'h7FF)) begin
                sentCount <= sentCount + 11'd1;
            end
        end
    end

    always_comb begin
        logic [7:0]   sym1;
        logic [7:0]   sym2;
        logic [7:0]   sym4;
        logic [7:0]   fill;
        logic [127:0] laneWord;
        payload  = '0;
        sym1     = useLink ? linkReg : PAD;
        sym2     = PAD;
        sym4     = (osKind == OS_TS2) ? {rateReg[7], upcReg, rateReg[5:0]} : rateReg;
        fill     = (osKind == OS_TS2) ? 8'h45 : 8'h4A;
        laneWord = '0;
        if (osValid && ((osKind == OS_TS1) || (osKind == OS_TS2))) begin
            for (int unsigned i = 0; i < 16; i++) begin
                sym2     = useLane ? 8'(i) : PAD;
                laneWord = {{10{fill}}, 8'h00, sym4, NFTS, sym2, sym1, 8'hBC};
                if (5'(i) < lanesReg) begin
                    payload[i*128 +: 128] = laneWord;
                end
            end
        end
    end

    assign seqIf.orderedSets      = payload;
    assign seqIf.osValid          = osValid;
    assign seqIf.txElectricalIdle = txElecIdle;
    assign seqIf.finish           = finish;
    assign seqIf.busy             = (state != IDLE);
    assign seqIf.sentCount        = sentCount;

endmodule

// File: doc/tx_os_sequencer.md
# tx_os_sequencer

Transmit-side ordered-set sequencer for the LTSSM. For the current training substate, it builds the per-lane TS1/TS2/idle payloads for up to 16 lanes. It streams them to the TX lane datapath over a valid/ready handshake, counts accepted sets against the substate's minimum transmit count and pulses `finish` when the minimum is met. It sits beside the master LTSSM, mirroring the receive-side ordered-set checkers.

## Interface
- `DEVICETYPE`, 0: 1 = downstream port (drives link number from Config.LinkWidth.Start); 0 = upstream port (PAD until Config.LinkWidth.Accept).
- `NFTS`, 8'd16: value placed in symbol 3 of every TS.
- `clk` input 1: single clock; all logic rising-edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: pulse; latch `substate` and begin the sequence for it.
- `stop` input 1: pulse; end transmission, return to IDLE.
- `substate` input 4: LTSSM substate code, sampled only with `start`.
- `linkNumber` input 8: link number field.
- `rateId` input 8: data-rate identifier.
- `upConfigureCapability` input 1: merged into the TS2 rate field.
- `numberOfDetectedLanes` input 5: active lane count, 0–16.
- `osReady` input 1: TX datapath accepts the presented set this cycle.
- `orderedSets` output 2048: lane i at bits [i*128+127 : i*128]; symbol k at [k*8+7 : k*8] within a lane.
- `osValid` output 1: `orderedSets` is valid.
- `txElectricalIdle` output 1: request transmitter electrical idle.
- `finish` output 1: one-cycle pulse, minimum count reached.
- `busy` output 1: not in IDLE.
- `sentCount` output 11: sets accepted in the current sequence.

## Operation
- FSM states: IDLE, SEND, HOLD (minimum met, still sending), QUIET (no-OS substates).
- Substate table (type, link field, lane field, minimum count):
  - 0–1 Detect: QUIET, `txElectricalIdle`=1.
  - 2 Polling.Active: TS1, PAD, PAD, 1024.
  - 3 Polling.Config: TS2, PAD, PAD, 16.
  - 4 Config.LinkWidth.Start: TS1, `linkNumber` if DEVICETYPE=1 else PAD, PAD, 16.
  - 5 LinkWidth.Accept: TS1, link, PAD, 2.
  - 6 Lanenum.Wait: TS1, link, lane i, 2.
  - 7 Lanenum.Accept: TS1, link, lane i, 2.
  - 8 Config.Complete: TS2, link, lane i, 16.
  - 9 Config.Idle: all-zero idle data, 16.
  - 10 L0 and 11–15: QUIET, `txElectricalIdle`=0.
- TS symbols:
  - symbol0 = 8'hBC.
  - symbol1 = link or PAD 8'hF7.
  - symbol2 = lane index i or 8'hF7.
  - symbol3 = NFTS.
  - symbol4: TS1 uses `rateId`; TS2 uses {rateId[7], upConfigureCapability, rateId[5:0]}.
  - symbol5 = 8'h00.
  - symbols 6–15: 8'h4A for TS1, 8'h45 for TS2.
- Lanes i ≥ `numberOfDetectedLanes` are driven all-zero. A value >16 is treated as 16. A value of 0 zeroes all lanes, but the handshake still runs.
- `linkNumber`, `rateId`, `upConfigureCapability` and `numberOfDetectedLanes` are latched at `start`. Changes to them mid-sequence are ignored.
- An accepted set is a cycle with `osValid` && `osReady`. Each one increments `sentCount`, which saturates at 2047.
- SEND → HOLD on the accept that makes `sentCount` equal the minimum; `finish` pulses that cycle.
- HOLD keeps transmitting the same pattern, with no further `finish`, until `stop` or `start`.
- QUIET: `osValid`=0. `finish` pulses the cycle after `start`, and the FSM stays in QUIET until `stop` or `start`.
- `start` in any state restarts: new substate latched, `sentCount` cleared. `start` and `stop` in the same cycle: `start` wins.
- `stop` → IDLE, `sentCount` cleared, `osValid`=0, `txElectricalIdle`=0.

## Timing
- Reset values: all outputs 0; FSM in IDLE.
- `start` at cycle t:
  - `busy`, `osValid` (or `txElectricalIdle` for Detect) and `orderedSets` are registered and valid from t+1.
  - `sentCount` reads 0 at t+1.
- `orderedSets` is stable while `osValid`=1 and `osReady`=0.
- `finish` is combinational from the registered state plus the counter compare and `osReady`. It is high exactly in the accepting cycle of set number *minimum*.
- Back-to-back accepts: one set per cycle. Minimum reached in N accept cycles, e.g. 1024 cycles for Polling.Active with `osReady` tied high.
- `reset` mid-sequence: next cycle all outputs are 0, IDLE.

## Test plan
- Polling.Active, `numberOfDetectedLanes`=4, `osReady`=1:
  - from t+1, lanes 0–3 carry BC,F7,F7,10,rateId,00,4A×10; lanes 4–15 are 0.
  - `finish` pulses at cycle t+1024; `sentCount`=1024; HOLD continues.
- Config.Complete, `linkNumber`=8'h05, `osReady` toggling 1/0:
  - lane 2 symbols 1,2 = 05,02; symbol 6 = 45.
  - `finish` on the 16th accept, after 31 cycles.
  - payload held stable during ready-low cycles.
- Substate 4, DEVICETYPE=0 vs 1 → symbol1 is F7 vs `linkNumber`; `finish` after 16 accepts.
- Detect (`substate`=0): `txElectricalIdle`=1, `osValid`=0, `finish` at t+1; `stop` → all outputs 0 next cycle.
- Restart and reset behaviour:
  - `start` with new substate 8 at `sentCount`=500 of Polling.Active → `sentCount` 0, TS2 pattern next cycle.
  - `start`+`stop` in the same cycle → sequence restarts.
  - `reset` mid-sequence → all outputs 0.
